// File: rtl/keypad_scan_if.sv
// rtl/keypad_scan_if.sv - keypad matrix and key-event signals of keypad_scan
interface keypad_scan_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row_in,
    output col_out,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_in,
    input  col_out,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad scanner with press/release debounce and key strobe
// Optional KEYPAD_HEXMAP_EN: key_code follows the printed legend instead of row*4+col.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20
) (
  input logic           clk,
  input logic           rst,
  keypad_scan_if.master kp
);

  localparam int             DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]     DB_LIMIT = 8'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [3:0]       sync1, row;
  logic [1:0]       col_idx, col_nx;
  logic [1:0]       row_sel, row_sel_nx;
  logic [7:0]       count, count_nx;
  logic             key_low, accept, release_done;
  logic [3:0]       key_code_r;
  logic             key_valid_r, key_held_r;

  function automatic logic [1:0] lowest_low(input logic [3:0] r);
    casez (r)
      4'b???0: return 2'd0;
      4'b??01: return 2'd1;
      4'b?011: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
`ifdef KEYPAD_HEXMAP_EN
    case ({r, c})
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hE;
      4'd13:   return 4'h0;
      4'd14:   return 4'hF;
      default: return 4'hD;
    endcase
`else
    return {r, c};
`endif
  endfunction

  assign tick    = (div == DIV_LAST);
  assign key_low = ~row[row_sel];

  // While a key is being tracked col_idx is frozen, so it doubles as the latched column.
  always_comb begin
    state_nx     = state;
    col_nx       = col_idx;
    row_sel_nx   = row_sel;
    count_nx     = count;
    accept       = 1'b0;
    release_done = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (row != 4'hF) begin
            row_sel_nx = lowest_low(row);
            count_nx   = 8'd1;
            state_nx   = DEBOUNCE;
          end else begin
            col_nx = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (key_low) begin
            if (count >= DB_LIMIT) begin
              accept   = 1'b1;
              state_nx = PRESSED;
            end else begin
              count_nx = sat_inc(count);
            end
          end else begin
            count_nx = 8'd0;
            col_nx   = col_idx + 2'd1;
            state_nx = SCAN;
          end
        end
        PRESSED: begin
          if (!key_low) begin
            count_nx = 8'd1;
            state_nx = RELEASE;
          end
        end
        default: begin
          if (!key_low) begin
            if (count >= DB_LIMIT) begin
              release_done = 1'b1;
              col_nx       = col_idx + 2'd1;
              state_nx     = SCAN;
            end else begin
              count_nx = sat_inc(count);
            end
          end else begin
            count_nx = 8'd0;
            state_nx = PRESSED;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      div         <= '0;
      sync1       <= 4'hF;
      row         <= 4'hF;
      col_idx     <= 2'd0;
      row_sel     <= 2'd0;
      count       <= 8'd0;
      key_code_r  <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state       <= state_nx;
      div         <= tick ? '0 : div + 1'b1;
      sync1       <= kp.row_in;
      row         <= sync1;
      col_idx     <= col_nx;
      row_sel     <= row_sel_nx;
      count       <= count_nx;
      key_valid_r <= accept;
      if (accept) begin
        key_code_r <= key_map(row_sel, col_idx);
        key_held_r <= 1'b1;
      end else if (release_done) begin
        key_held_r <= 1'b0;
      end
    end
  end

  assign kp.col_out   = ~(4'b0001 << col_idx);
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 matrix keypad: drives active-low one-hot columns and reads active-low rows.
- Debounces presses and releases, then reports one key code per press with a single-cycle valid strobe.
- Acts as the front-panel input counterpart to the multiplexed 7-segment display driver.
- key_code/key_valid feed the digit registers of the display path.

Parameters:
- SCAN_DIV, 50000, clk cycles per scan tick (1 kHz at 50 MHz).
- DEBOUNCE_TICKS, 20, consecutive stable scan ticks required to accept a press or a release (1..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  output  4  keypad column drive, active-low one-hot.
- key_code  output  4  code of the last accepted key; held until the next accept.
- key_valid  output  1  one-cycle strobe when key_code updates.
- key_held  output  1  high while the accepted key remains pressed, including the release debounce.

Behaviour:
- Reset values (rst sampled high at a clk edge):
  - col_out=4'b1110, key_code=0, key_valid=0, key_held=0.
  - State=SCAN, column index=0, divider=0, debounce count=0, synchronizer flops=4'b1111.
  - A reset asserted mid-debounce or while held aborts the operation with no strobe.
- Input sync: row_in passes through a 2-flop synchronizer; "row" below means the synchronized value.
- Tick: the divider counts 0..SCAN_DIV-1; tick=1 for one clk when divider==SCAN_DIV-1, then the divider wraps to 0. All FSM decisions happen only on tick cycles.
- Column drive: col_out = ~(4'b0001 << col_idx). Column order is 0,1,2,3,0,...
- SCAN:
  - On tick, if row != 4'b1111: latch col_idx and the lowest-index low row bit; count=1; go to DEBOUNCE. The column stays frozen.
  - Otherwise col_idx increments mod 4.
- DEBOUNCE:
  - On tick, if the latched row bit is low: count++.
  - When count reaches DEBOUNCE_TICKS: key_code=code(row,col), key_valid=1 for the next single clk, key_held=1, go to PRESSED.
  - If the latched row bit is high: count=0, col_idx increments mod 4, go to SCAN, no strobe.
  - If DEBOUNCE_TICKS=1, the accept happens on the first DEBOUNCE tick.
- PRESSED:
  - On tick, if the latched row bit is high: count=1, go to RELEASE.
  - Other keys are ignored, including other rows in the same column.
- RELEASE:
  - On tick, if the latched row bit is high: count++. When count reaches DEBOUNCE_TICKS: key_held=0, col_idx increments mod 4, go to SCAN.
  - If the latched row bit is low: count=0, go to PRESSED. No new strobe (bounce on release).
- code(row,col) = {row[1:0], col[1:0]}, i.e. row*4+col.
- Simultaneous keys:
  - Same column: the lowest row index wins.
  - Different columns: the first one scanned wins.
- The count register is 8 bits and saturates; it never wraps.

Optional Feature:
- Macro KEYPAD_HEXMAP_EN.
- When defined, key_code uses the printed-legend map:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: E(*),0,F(#),D
  - Example: row3/col1 gives 4'h0; row0/col0 gives 4'h1.
- When undefined, key_code is the raw row*4+col.
- Timing and handshakes are identical in both builds.

Test Plan:
- Reset: hold rst 3 clks with row_in=4'b0000 -> col_out=4'b1110, key_valid=0, key_held=0, key_code=0. The first tick occurs SCAN_DIV clks after rst drops.
- Clean press (SCAN_DIV=4, DEBOUNCE_TICKS=3, raw map): hold row1 low only while col_out=4'b1011 (col2) -> exactly one key_valid pulse, 3 ticks after detection, key_code=4'd6, key_held=1. col_out stays at 4'b1011 until the release completes 3 ticks later, then key_held=0.
- Press bounce: row0/col0 low for 2 ticks, high for 1, then low steady -> no strobe from the first burst. The second detection strobes once with key_code=4'd0.
- Release bounce: while PRESSED, release for 1 tick then press again -> key_held stays 1, no second key_valid. A final stable release drops key_held after 3 ticks.
- Two keys in col3, rows 2 and 3 low -> key_code=4'd11 (row2 wins). With KEYPAD_HEXMAP_EN the same stimulus gives key_code=4'hC.
- Reset mid-DEBOUNCE: assert rst after 2 debounce ticks -> no key_valid, outputs at reset values, and scanning restarts from col0.
